top: RTL and testbench



---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_timing.sv | 47 ++++
 rtl/top.sv | 117 +++++++++++
 tb/tb_top.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and colour types for the VGA screensaver core.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = 525;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_LAST   = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_VIS_LAST   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  localparam int SEL_CHECKER = 0;
  localparam int SEL_FRACTAL = 1;

  typedef logic [3:0] color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } rgb_t;

  localparam rgb_t RGB_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/vga_timing.sv
// VGA scan counters: raster position, visible flag, end-of-frame strobe and unregistered active-low syncs.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       visible,
  output logic       eof,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  logic [9:0] hc_r;
  logic [9:0] vc_r;
  logic       h_end_s;
  logic       v_end_s;

  assign h_end_s = (hc_r == H_LAST);
  assign v_end_s = (vc_r == V_LAST);

  // Horizontal/vertical raster counters; vc advances only when a line completes
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_r <= 10'd0;
      vc_r <= 10'd0;
    end else if (h_end_s) begin
      hc_r <= 10'd0;
      if (v_end_s) begin
        vc_r <= 10'd0;
      end else begin
        vc_r <= vc_r + 10'd1;
      end
    end else begin
      hc_r <= hc_r + 10'd1;
    end
  end

  assign hc        = hc_r;
  assign vc        = vc_r;
  assign visible   = (hc_r <= H_VIS_LAST) && (vc_r <= V_VIS_LAST);
  assign eof       = h_end_s && v_end_s;
  assign hsync_raw = !((hc_r >= H_SYNC_START) && (hc_r <= H_SYNC_END));
  assign vsync_raw = !((vc_r >= V_SYNC_START) && (vc_r <= V_SYNC_END));

endmodule

// File: rtl/top.sv
// VGA screensaver top: frame counter, checkerboard/fractal pattern mux and registered outputs.
// Optional build macro BORDER_EN paints a one-pixel white frame around the visible area.
module top
  import vga_pkg::*;
#(
  parameter int IMAGE_SELECT = 0
) (
  input  logic       clk_25_175,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  logic [9:0] hc_s;
  logic [9:0] vc_s;
  logic       visible_s;
  logic       eof_s;
  logic       hsync_s;
  logic       vsync_s;
  logic [7:0] fc_r;
  logic [9:0] sx_s;
  logic [9:0] sy_s;
  logic [8:0] fx_s;
  logic [8:0] fy_s;
  logic [3:0] fxor_s;
  rgb_t       checker_s;
  rgb_t       fractal_s;
  rgb_t       pix_s;

  vga_timing u_timing (
    .clk       (clk_25_175),
    .rst       (rst),
    .hc        (hc_s),
    .vc        (vc_s),
    .visible   (visible_s),
    .eof       (eof_s),
    .hsync_raw (hsync_s),
    .vsync_raw (vsync_s)
  );

  // Frame counter drives the diagonal scroll and the dark-cell red level
  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      fc_r <= 8'd0;
    end else if (eof_s) begin
      fc_r <= fc_r + 8'd1;
    end else begin
      fc_r <= fc_r;
    end
  end

  // Scrolling checkerboard: squares where sx[5] and sy[5] agree are white
  always_comb begin
    sx_s = hc_s + {2'b00, fc_r};
    sy_s = vc_s + {2'b00, fc_r};
    if (sx_s[5] == sy_s[5]) begin
      checker_s = RGB_WHITE;
    end else begin
      checker_s = '{r: fc_r[7:4], g: 4'h0, b: 4'h8};
    end
  end

  // Sierpinski fractal from the bitwise AND of the low 9 coordinate bits
  always_comb begin
    fx_s   = hc_s[8:0];
    fy_s   = vc_s[8:0];
    fxor_s = fx_s[3:0] ^ fy_s[3:0];
    if ((fx_s & fy_s) == 9'd0) begin
      fractal_s = RGB_WHITE;
    end else begin
      fractal_s = '{r: fx_s[8:5], g: fy_s[8:5], b: fxor_s};
    end
  end

  // Pattern select, optional border overlay, then blanking outside the visible area
  always_comb begin
    pix_s = RGB_BLACK;
    case (IMAGE_SELECT)
      SEL_CHECKER: pix_s = checker_s;
      SEL_FRACTAL: pix_s = fractal_s;
      default:     pix_s = RGB_BLACK;
    endcase
`ifdef BORDER_EN
    if ((hc_s == 10'd0) || (hc_s == H_VIS_LAST) || (vc_s == 10'd0) || (vc_s == V_VIS_LAST)) begin
      pix_s = RGB_WHITE;
    end else begin
      pix_s = pix_s;
    end
`endif
    if (!visible_s) begin
      pix_s = RGB_BLACK;
    end else begin
      pix_s = pix_s;
    end
  end

  // Output registers keep syncs and colour aligned one cycle behind the counters
  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      r     <= 4'h0;
      g     <= 4'h0;
      b     <= 4'h0;
    end else begin
      hsync <= hsync_s;
      vsync <= vsync_s;
      r     <= pix_s.r;
      g     <= pix_s.g;
      b     <= pix_s.b;
    end
  end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the VGA screensaver: one instance per IMAGE_SELECT value (0, 1, 2).
module tb_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs0, vs0, hs1, vs1, hs2, vs2;
  logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;

  top #(.IMAGE_SELECT(0)) u0 (.clk_25_175(clk), .rst(rst), .hsync(hs0), .vsync(vs0), .r(r0), .g(g0), .b(b0));
  top #(.IMAGE_SELECT(1)) u1 (.clk_25_175(clk), .rst(rst), .hsync(hs1), .vsync(vs1), .r(r1), .g(g1), .b(b1));
  top #(.IMAGE_SELECT(2)) u2 (.clk_25_175(clk), .rst(rst), .hsync(hs2), .vsync(vs2), .r(r2), .g(g2), .b(b2));

  always #20 clk = ~clk;

  typedef struct {
    int          idx;
    logic [11:0] exp;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  item_t q2[$];
  int    total = 0;
  int    bad   = 0;
  int    n     = 0;

  // Reference pixel colour {r,g,b} for pattern sel at (x,y) in frame f
  function automatic logic [11:0] model(input int sel, input int x, input int y, input int f);
    int sx, sy, xx, yy;
    if (x >= 640 || y >= 480) return 12'h000;
`ifdef BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 12'hFFF;
`endif
    if (sel == 0) begin
      sx = (x + f) % 1024;
      sy = (y + f) % 1024;
      if (((sx / 32) % 2) == ((sy / 32) % 2)) return 12'hFFF;
      return 12'(((f / 16) % 16) * 256 + 8);
    end else if (sel == 1) begin
      xx = x % 512;
      yy = y % 512;
      if ((xx & yy) == 0) return 12'hFFF;
      return 12'(((xx / 32) % 16) * 256 + ((yy / 32) % 16) * 16 + ((xx ^ yy) % 16));
    end
    return 12'h000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic item_t mk(input int sel, input int x, input int y, input int f);
    item_t it;
    it.idx = f * 420000 + y * 800 + x;
    it.exp = model(sel, x, y, f);
    return it;
  endfunction

  initial begin
    item_t it;
    int    p;
    int    h_low, z_cnt, vlow;
    bit    vs_seen, vs_done;
    h_low = 0; z_cnt = 0; vlow = 0; vs_seen = 1'b0; vs_done = 1'b0;

    // reset held for two edges
    rst = 1'b1;
    step();
    chk("rst_hsync", {31'd0, hs0}, 32'd1);
    chk("rst_vsync", {31'd0, vs0}, 32'd1);
    chk("rst_rgb", {20'd0, r0, g0, b0}, 32'd0);
    step();
    chk("rst_rgb_fractal", {20'd0, r1, g1, b1}, 32'd0);
    rst = 1'b0;
    n = 0;

    // expectations, in scan order, for each instance
    q0.push_back(mk(0, 0, 0, 0));
    q0.push_back(mk(0, 32, 0, 0));
    q0.push_back(mk(0, 32, 1, 0));
    q0.push_back(mk(0, 32, 32, 0));
    q0.push_back(mk(0, 639, 100, 0));
    q0.push_back(mk(0, 700, 100, 0));
    q0.push_back(mk(0, 31, 0, 1));
    q1.push_back(mk(1, 3, 1, 0));
    q1.push_back(mk(1, 1, 2, 0));
    q1.push_back(mk(1, 511, 256, 0));
    q1.push_back(mk(1, 3, 1, 1));
    q1.push_back(mk(1, 1, 2, 1));
    q2.push_back(mk(2, 0, 0, 0));
    q2.push_back(mk(2, 100, 100, 0));

    // output after edge n shows scan position n-1
    while (n < 421700) begin
      step();
      p = n - 1;
      if (p < 2400) begin
        if (hs0 == 1'b0) h_low++;
        if ({r0, g0, b0} == 12'h000) z_cnt++;
        if ((p % 800) == 799) begin
          chk($sformatf("hsync_low_line%0d", p / 800), h_low, 32'd96);
          chk($sformatf("blank_line%0d", p / 800), z_cnt, 32'd160);
          h_low = 0;
          z_cnt = 0;
        end
      end
      if (!vs_seen && vs0 == 1'b0) begin
        vs_seen = 1'b1;
        vlow = 1;
        chk("first_vsync_fall", n, 32'd392001);
      end else if (vs_seen && !vs_done) begin
        if (vs0 == 1'b0) begin
          vlow++;
        end else begin
          vs_done = 1'b1;
          chk("vsync_low_len", vlow, 32'd1600);
        end
      end
      if (q0.size() != 0 && q0[0].idx == p) begin
        it = q0.pop_front();
        chk($sformatf("chk_pix_%0d", p), {20'd0, r0, g0, b0}, {20'd0, it.exp});
      end
      if (q1.size() != 0 && q1[0].idx == p) begin
        it = q1.pop_front();
        chk($sformatf("frac_pix_%0d", p), {20'd0, r1, g1, b1}, {20'd0, it.exp});
      end
      if (q2.size() != 0 && q2[0].idx == p) begin
        it = q2.pop_front();
        chk($sformatf("sel2_pix_%0d", p), {20'd0, r2, g2, b2}, {20'd0, it.exp});
      end
    end
    chk("sb_drained", q0.size() + q1.size() + q2.size(), 32'd0);
    chk("vsync_done", {31'd0, vs_done}, 32'd1);

    // mid-frame reset, then scan restarts at (0,0) of frame 0
    rst = 1'b1;
    step();
    chk("midrst_rgb", {20'd0, r0, g0, b0}, 32'd0);
    chk("midrst_hsync", {31'd0, hs0}, 32'd1);
    rst = 1'b0;
    step();
    chk("restart_pix00", {20'd0, r0, g0, b0}, {20'd0, model(0, 0, 0, 0)});
    step();
    chk("restart_pix10_frac", {20'd0, r1, g1, b1}, {20'd0, model(1, 1, 0, 0)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
